// File: rtl/bsg_bp_mem_block_responder.sv
// Block-to-word memory responder.
// Takes one cache-block command at a time from the tile, issues it as in-order
// word transactions (critical word first, wrapping inside the size-aligned
// region), gathers read words back into one block response and echoes the header.
module bsg_bp_mem_block_responder #(
  parameter int paddr_width_p  = 40,
  parameter int block_width_p  = 512,
  parameter int word_width_p   = 64,
  parameter int header_width_p = 96
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] mem_cmd_header_i,
  input  logic [paddr_width_p-1:0]  mem_cmd_addr_i,
  input  logic [2:0]                mem_cmd_size_i,
  input  logic                      mem_cmd_wr_i,
  input  logic [block_width_p-1:0]  mem_cmd_data_i,
  input  logic                      mem_cmd_v_i,
  output logic                      mem_cmd_ready_o,

  output logic [header_width_p-1:0] mem_resp_header_o,
  output logic [block_width_p-1:0]  mem_resp_data_o,
  output logic                      mem_resp_v_o,
  input  logic                      mem_resp_yumi_i,

  output logic [paddr_width_p-1:0]  word_cmd_addr_o,
  output logic [word_width_p-1:0]   word_cmd_data_o,
  output logic                      word_cmd_wr_o,
  output logic                      word_cmd_v_o,
  input  logic                      word_cmd_ready_i,

  input  logic [word_width_p-1:0]   word_resp_data_i,
  input  logic                      word_resp_v_i,
  output logic                      word_resp_yumi_o
);

  localparam int words_lp     = block_width_p / word_width_p;
  localparam int lg_words_lp  = $clog2(words_lp);
  localparam int lane_w_lp    = (lg_words_lp > 0) ? lg_words_lp : 1;
  localparam int cnt_width_lp = $clog2(words_lp + 1);
  localparam int byte_lg_lp   = $clog2(word_width_p / 8);
  localparam int bit_lg_lp    = $clog2(word_width_p);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // log2 of the word count for a transfer size: at least one word, at most a block
  function automatic int lg_words_for_size(input logic [2:0] size);
    int lg;
    lg = int'(size) + 3 - bit_lg_lp;
    if (lg < 0) begin
      lg = 0;
    end else if (lg > lg_words_lp) begin
      lg = lg_words_lp;
    end else begin
      lg = lg;
    end
    return lg;
  endfunction

  function automatic logic [cnt_width_lp-1:0] words_for_size(input logic [2:0] size);
    return cnt_width_lp'(32'd1 << lg_words_for_size(size));
  endfunction

  // Byte mask of the size-aligned region the word walk wraps inside
  function automatic logic [paddr_width_p-1:0] region_mask(input logic [2:0] size);
    logic [63:0] span;
    span = 64'd1 << (lg_words_for_size(size) + byte_lg_lp);
    return paddr_width_p'(span - 64'd1);
  endfunction

  state_e                    state_r, state_n;
  logic [header_width_p-1:0] header_r;
  logic [paddr_width_p-1:0]  addr_r;
  logic [paddr_width_p-1:0]  mask_r;
  logic                      wr_r;
  logic [block_width_p-1:0]  wdata_r;
  logic [block_width_p-1:0]  rdata_r;
  logic [cnt_width_lp-1:0]   n_r;
  logic [cnt_width_lp-1:0]   issue_cnt_r;
  logic [cnt_width_lp-1:0]   resp_cnt_r;

  logic                      ready_s;
  logic                      cmd_fire_s;
  logic                      word_v_s;
  logic                      issue_fire_s;
  logic                      yumi_s;
  logic                      resp_v_s;
  logic [lane_w_lp-1:0]      issue_lane_s;
  logic [lane_w_lp-1:0]      resp_lane_s;
  logic [paddr_width_p-1:0]  koff_s;
  logic [paddr_width_p-1:0]  word_addr_s;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_n    = state_r;
    ready_s    = 1'b0;
    word_v_s   = 1'b0;
    yumi_s     = 1'b0;
    resp_v_s   = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = ~reset_i;
        if (mem_cmd_v_i & ~reset_i) begin
          state_n = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        word_v_s = (issue_cnt_r < n_r);
        yumi_s   = word_resp_v_i & (resp_cnt_r < issue_cnt_r);
        if (yumi_s && (resp_cnt_r == (n_r - cnt_width_lp'(1)))) begin
          state_n = RESP;
        end else begin
          state_n = BUSY;
        end
      end
      RESP: begin
        resp_v_s = 1'b1;
        if (mem_resp_yumi_i) begin
          state_n = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    cmd_fire_s   = ready_s & mem_cmd_v_i;
    issue_fire_s = word_v_s & word_cmd_ready_i;
  end

  // Word address walk: keep the region bits of the base, wrap the offset inside it
  always_comb begin
    issue_lane_s = lane_w_lp'(issue_cnt_r);
    resp_lane_s  = lane_w_lp'(resp_cnt_r);
    koff_s       = paddr_width_p'(issue_cnt_r) << byte_lg_lp;
    word_addr_s  = (addr_r & ~mask_r) | ((addr_r + koff_s) & mask_r);
  end

  // Command latch, issue/response counters and read-data gather
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      header_r    <= '0;
      addr_r      <= '0;
      mask_r      <= '0;
      wr_r        <= 1'b0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      n_r         <= '0;
      issue_cnt_r <= '0;
      resp_cnt_r  <= '0;
    end else if (cmd_fire_s) begin
      header_r    <= mem_cmd_header_i;
      addr_r      <= mem_cmd_addr_i;
      mask_r      <= region_mask(mem_cmd_size_i);
      wr_r        <= mem_cmd_wr_i;
      wdata_r     <= mem_cmd_data_i;
      rdata_r     <= '0;
      n_r         <= words_for_size(mem_cmd_size_i);
      issue_cnt_r <= '0;
      resp_cnt_r  <= '0;
    end else begin
      if (issue_fire_s) begin
        issue_cnt_r <= issue_cnt_r + cnt_width_lp'(1);
      end
      if (yumi_s) begin
        resp_cnt_r <= resp_cnt_r + cnt_width_lp'(1);
        if (!wr_r) begin
          rdata_r[int'(resp_lane_s)*word_width_p +: word_width_p] <= word_resp_data_i;
        end
      end
    end
  end

  assign mem_cmd_ready_o   = ready_s;
  assign mem_resp_v_o      = resp_v_s;
  assign mem_resp_header_o = header_r;
  assign mem_resp_data_o   = rdata_r;
  assign word_cmd_v_o      = word_v_s;
  assign word_cmd_addr_o   = word_v_s ? word_addr_s : '0;
  assign word_cmd_data_o   = word_v_s ? wdata_r[int'(issue_lane_s)*word_width_p +: word_width_p] : '0;
  assign word_cmd_wr_o     = word_v_s & wr_r;
  assign word_resp_yumi_o  = yumi_s;

endmodule

// File: tb/tb_bsg_bp_mem_block_responder.sv
// Bench for bsg_bp_mem_block_responder: a behavioural word endpoint plus a
// transaction-level model of addresses, lanes and response data.
module tb_bsg_bp_mem_block_responder;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [95:0]   mem_cmd_header_i;
  logic [39:0]   mem_cmd_addr_i;
  logic [2:0]    mem_cmd_size_i;
  logic          mem_cmd_wr_i;
  logic [511:0]  mem_cmd_data_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [95:0]   mem_resp_header_o;
  logic [511:0]  mem_resp_data_o;
  logic          mem_resp_v_o;
  logic          mem_resp_yumi_i;
  logic [39:0]   word_cmd_addr_o;
  logic [63:0]   word_cmd_data_o;
  logic          word_cmd_wr_o;
  logic          word_cmd_v_o;
  logic          word_cmd_ready_i;
  logic [63:0]   word_resp_data_i;
  logic          word_resp_v_i;
  logic          word_resp_yumi_o;

  always #5 clk = ~clk;

  bsg_bp_mem_block_responder dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .mem_cmd_header_i  (mem_cmd_header_i),
    .mem_cmd_addr_i    (mem_cmd_addr_i),
    .mem_cmd_size_i    (mem_cmd_size_i),
    .mem_cmd_wr_i      (mem_cmd_wr_i),
    .mem_cmd_data_i    (mem_cmd_data_i),
    .mem_cmd_v_i       (mem_cmd_v_i),
    .mem_cmd_ready_o   (mem_cmd_ready_o),
    .mem_resp_header_o (mem_resp_header_o),
    .mem_resp_data_o   (mem_resp_data_o),
    .mem_resp_v_o      (mem_resp_v_o),
    .mem_resp_yumi_i   (mem_resp_yumi_i),
    .word_cmd_addr_o   (word_cmd_addr_o),
    .word_cmd_data_o   (word_cmd_data_o),
    .word_cmd_wr_o     (word_cmd_wr_o),
    .word_cmd_v_o      (word_cmd_v_o),
    .word_cmd_ready_i  (word_cmd_ready_i),
    .word_resp_data_i  (word_resp_data_i),
    .word_resp_v_i     (word_resp_v_i),
    .word_resp_yumi_o  (word_resp_yumi_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Endpoint state: data returned for the i-th word issued, log of issued words
  logic [63:0] ep_data [8];
  int          ep_cnt  = 0;
  int          ep_rcnt = 0;
  int          ep_mode = 2;   // 0 random, 1 toggling ready, 2 always ready
  logic [39:0] log_addr [$];
  logic [63:0] log_data [$];
  logic        log_wr   [$];
  logic [63:0] pend_q   [$];

  // Word endpoint: samples handshakes mid-cycle, updates just after the edge
  initial begin
    logic        cf, rf, cw;
    logic [39:0] ca;
    logic [63:0] cd;
    word_cmd_ready_i = 1'b0;
    word_resp_v_i    = 1'b0;
    word_resp_data_i = 64'd0;
    forever begin
      @(negedge clk);
      cf = word_cmd_v_o & word_cmd_ready_i;
      ca = word_cmd_addr_o;
      cd = word_cmd_data_o;
      cw = word_cmd_wr_o;
      rf = word_resp_v_i & word_resp_yumi_o;
      @(posedge clk);
      #1;
      if (reset_i) begin
        pend_q.delete();
        word_cmd_ready_i = 1'b0;
        word_resp_v_i    = 1'b0;
        word_resp_data_i = 64'd0;
      end else begin
        if (cf) begin
          log_addr.push_back(ca);
          log_data.push_back(cd);
          log_wr.push_back(cw);
          pend_q.push_back(ep_data[ep_cnt % 8]);
          ep_cnt++;
        end
        if (rf && pend_q.size() > 0) begin
          void'(pend_q.pop_front());
          ep_rcnt++;
        end
        case (ep_mode)
          0:       word_cmd_ready_i = 1'($urandom_range(0, 1));
          1:       word_cmd_ready_i = ~word_cmd_ready_i;
          default: word_cmd_ready_i = 1'b1;
        endcase
        if (pend_q.size() > 0 && (ep_mode != 0 || $urandom_range(0, 2) != 0)) begin
          word_resp_v_i    = 1'b1;
          word_resp_data_i = pend_q[0];
        end else begin
          word_resp_v_i    = 1'b0;
          word_resp_data_i = 64'd0;
        end
      end
    end
  end

  task automatic run_txn(input logic [2:0] size, input logic wr, input logic [39:0] addr,
                         input logic [511:0] wdata, input int hold, input bit do_reset);
    logic [95:0]  hdr;
    logic [511:0] exp_data;
    logic [511:0] snap;
    logic [39:0]  region;
    logic [39:0]  off;
    logic [39:0]  exp_addr;
    int           n;
    int           guard;
    bit           bad;
    hdr = {$urandom, $urandom, $urandom};
    n = ((1 << size) * 8) / 64;
    if (n < 1) n = 1;
    if (n > 8) n = 8;
    exp_data = '0;
    if (!wr) begin
      for (int i = 0; i < n; i++) exp_data[i*64 +: 64] = ep_data[i];
    end
    log_addr.delete();
    log_data.delete();
    log_wr.delete();
    ep_cnt  = 0;
    ep_rcnt = 0;

    @(posedge clk);
    #1;
    mem_cmd_header_i = hdr;
    mem_cmd_addr_i   = addr;
    mem_cmd_size_i   = size;
    mem_cmd_wr_i     = wr;
    mem_cmd_data_i   = wdata;
    mem_cmd_v_i      = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_cmd_ready_o && guard < 50);
    check_eq("cmd_accept", 512'(mem_cmd_ready_o), 512'd1);
    @(posedge clk);
    #1;
    mem_cmd_v_i = 1'b0;

    if (do_reset) begin
      guard = 0;
      while (ep_rcnt < 3 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      check_eq("reach_3_resp", 512'(ep_rcnt), 512'd3);
      #1;
      reset_i = 1'b1;
      #1;
      check_eq("rst_mid_ready", 512'(mem_cmd_ready_o), 512'd0);
      check_eq("rst_mid_wordv", 512'(word_cmd_v_o), 512'd0);
      check_eq("rst_mid_yumi", 512'(word_resp_yumi_o), 512'd0);
      check_eq("rst_mid_respv", 512'(mem_resp_v_o), 512'd0);
      check_eq("rst_mid_data", mem_resp_data_o, 512'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      reset_i = 1'b0;
      bad = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (mem_resp_v_o || word_cmd_v_o) bad = 1'b1;
      end
      check_eq("rst_no_resp", 512'(bad), 512'd0);
      check_eq("rst_ready_back", 512'(mem_cmd_ready_o), 512'd1);
      return;
    end

    bad = 1'b0;
    guard = 0;
    while (!mem_resp_v_o && guard < 1000) begin
      if (mem_cmd_ready_o) bad = 1'b1;
      @(negedge clk);
      guard++;
    end
    check_eq("resp_valid", 512'(mem_resp_v_o), 512'd1);
    check_eq("ready_low_busy", 512'(bad), 512'd0);

    snap = mem_resp_data_o;
    bad  = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (mem_resp_data_o !== snap || !mem_resp_v_o || mem_cmd_ready_o || mem_resp_header_o !== hdr) bad = 1'b1;
    end
    check_eq("resp_stable", 512'(bad), 512'd0);
    check_eq("resp_header", 512'(mem_resp_header_o), 512'(hdr));
    check_eq("resp_data", mem_resp_data_o, exp_data);

    check_eq("word_count", 512'(log_addr.size()), 512'(n));
    region = 40'(n * 8);
    off    = addr % region;
    for (int k = 0; k < n; k++) begin
      if (k < log_addr.size()) begin
        exp_addr = addr - off + ((off + 40'(k * 8)) % region);
        check_eq($sformatf("word_addr[%0d]", k), 512'(log_addr[k]), 512'(exp_addr));
        check_eq($sformatf("word_wr[%0d]", k), 512'(log_wr[k]), 512'(wr));
        check_eq($sformatf("word_data[%0d]", k), 512'(log_data[k]), 512'(wdata[k*64 +: 64]));
      end
    end

    @(posedge clk);
    #1;
    mem_resp_yumi_i = 1'b1;
    @(posedge clk);
    #1;
    mem_resp_yumi_i = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 512'(mem_cmd_ready_o), 512'd1);
    check_eq("idle_respv", 512'(mem_resp_v_o), 512'd0);
  endtask

  // Main sequence: directed cases first, then randomized commands
  initial begin
    logic [511:0] wd;
    logic [63:0]  r64;
    reset_i          = 1'b1;
    mem_cmd_header_i = 96'd0;
    mem_cmd_addr_i   = 40'd0;
    mem_cmd_size_i   = 3'd0;
    mem_cmd_wr_i     = 1'b0;
    mem_cmd_data_i   = 512'd0;
    mem_cmd_v_i      = 1'b0;
    mem_resp_yumi_i  = 1'b0;
    for (int i = 0; i < 8; i++) ep_data[i] = 64'(8'h11 * (i + 1));

    repeat (3) @(negedge clk);
    check_eq("rst_ready", 512'(mem_cmd_ready_o), 512'd0);
    check_eq("rst_respv", 512'(mem_resp_v_o), 512'd0);
    check_eq("rst_wordv", 512'(word_cmd_v_o), 512'd0);
    check_eq("rst_yumi", 512'(word_resp_yumi_o), 512'd0);
    check_eq("rst_hdr", 512'(mem_resp_header_o), 512'd0);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 512'(mem_cmd_ready_o), 512'd1);

    ep_mode = 2;
    run_txn(3'd6, 1'b0, 40'h80_0000_40, 512'd0, 0, 1'b0);
    run_txn(3'd6, 1'b0, 40'h80_0000_58, 512'd0, 0, 1'b0);
    wd = '0;
    for (int k = 0; k < 8; k++) wd[k*64 +: 64] = 64'(k + 1);
    run_txn(3'd6, 1'b1, 40'h80_0000_00, wd, 0, 1'b0);
    ep_data[0] = 64'hDEAD_BEEF_CAFE_F00D;
    run_txn(3'd2, 1'b0, 40'h00_0000_1004, 512'd0, 0, 1'b0);

    ep_mode = 1;
    for (int i = 0; i < 8; i++) ep_data[i] = {$urandom, $urandom};
    run_txn(3'd6, 1'b0, 40'h12_3456_7808, 512'd0, 5, 1'b0);

    ep_mode = 2;
    run_txn(3'd6, 1'b0, 40'h80_0000_40, 512'd0, 0, 1'b1);
    for (int i = 0; i < 8; i++) ep_data[i] = {$urandom, $urandom};
    run_txn(3'd6, 1'b0, 40'h80_0000_68, 512'd0, 0, 1'b0);

    ep_mode = 0;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 8; i++) ep_data[i] = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) wd[k*64 +: 64] = {$urandom, $urandom};
      r64 = {$urandom, $urandom};
      run_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), r64[39:0], wd,
              $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
